// File: rtl/mux_scan.sv
`default_nettype none
// ============================================================================
// Module   : mux_scan
// Brief    : Registered CH:1 word multiplexer, manual select or masked
//            round-robin scan with a per-channel dwell and round-wrap pulse.
// Revision : 1.0 - initial release
// ============================================================================
module mux_scan #(
    parameter int WIDTH = 8,
    parameter int CH    = 4,
    parameter int SEL_W = 2,
    parameter int DWELL = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CH*WIDTH-1:0] d_in,
    input  logic [SEL_W-1:0]    sel,
    input  logic                mode,
    input  logic [CH-1:0]       en_mask,
    output logic [WIDTH-1:0]    m_out,
    output logic [SEL_W-1:0]    ch_out,
    output logic                m_valid,
    output logic                wrap
);

    localparam int                 c_NSLOT    = 2**SEL_W;
    localparam int                 c_CNT_W    = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(DWELL - 1);
    localparam logic [0:0]         c_ST_MANUAL = 1'b0;
    localparam logic [0:0]         c_ST_SCAN   = 1'b1;

    logic [0:0]         r_st;
    logic [SEL_W-1:0]   r_ptr;
    logic [c_CNT_W-1:0] r_cnt;

    logic [WIDTH-1:0]   w_slot [c_NSLOT];
    logic [c_NSLOT-1:0] w_mask;
    logic               w_scan_rule;
    logic [SEL_W-1:0]   w_idx;
    logic               w_advance;
    logic [SEL_W-1:0]   w_first;
    logic               w_first_hit;
    logic [SEL_W-1:0]   w_next;
    logic               w_next_hit;
    logic [SEL_W-1:0]   w_probe;

    // Index space is padded to 2**SEL_W slots; padding slots read as disabled.
    genvar gi;
    generate
        for (gi = 0; gi < c_NSLOT; gi++) begin : g_slot
            if (gi < CH) begin : g_live
                assign w_slot[gi] = d_in[gi*WIDTH +: WIDTH];
                assign w_mask[gi] = en_mask[gi];
            end else begin : g_pad
                assign w_slot[gi] = '0;
                assign w_mask[gi] = 1'b0;
            end
        end
    endgenerate

    always_comb begin
        w_scan_rule = (r_st == c_ST_SCAN) && mode;
        w_idx       = w_scan_rule ? r_ptr : sel;
        w_advance   = (|en_mask) && ((r_cnt == c_CNT_LAST) || !w_mask[r_ptr]);
        w_first     = '0;
        w_first_hit = 1'b0;
        w_next      = r_ptr;
        w_next_hit  = 1'b0;
        w_probe     = '0;
        // Circular search from ptr+1 visits ptr itself last, so a lone channel re-selects itself.
        for (int k = 0; k < CH; k++) begin
            w_probe = SEL_W'(k);
            if (!w_first_hit && w_mask[w_probe]) begin
                w_first     = w_probe;
                w_first_hit = 1'b1;
            end
            w_probe = SEL_W'((int'(r_ptr) + k + 1) % CH);
            if (!w_next_hit && w_mask[w_probe]) begin
                w_next     = w_probe;
                w_next_hit = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_st    <= c_ST_MANUAL;
            r_ptr   <= '0;
            r_cnt   <= '0;
            m_out   <= '0;
            ch_out  <= '0;
            m_valid <= 1'b0;
            wrap    <= 1'b0;
        end else begin
            ch_out <= w_idx;
            if (w_mask[w_idx]) begin
                m_out   <= w_slot[w_idx];
                m_valid <= 1'b1;
            end else begin
                m_out   <= '0;
                m_valid <= 1'b0;
            end
            wrap <= w_scan_rule && w_advance && (w_next <= r_ptr);

            if (r_st == c_ST_MANUAL) begin
                if (mode) begin
                    r_st  <= c_ST_SCAN;
                    r_ptr <= w_first;
                    r_cnt <= '0;
                end
            end else if (!mode) begin
                r_st <= c_ST_MANUAL;
            end else if (w_advance) begin
                r_ptr <= w_next;
                r_cnt <= '0;
            end else if (w_mask[r_ptr]) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: doc/mux_scan.md
# mux_scan

Parametrised, registered N:1 word multiplexer, the successor of the team's 2:1 bit mux. It selects one of CH channels of WIDTH bits each. The channel comes either from an external select (manual mode) or from an internal round-robin scanner that dwells DWELL cycles per enabled channel and skips masked channels. It sits between parallel sensor/data sources and a single downstream consumer, and flags each completed scan round.

## Interface
Parameters:
- WIDTH, 8: data width per channel (>=1)
- CH, 4: channel count (2..16)
- SEL_W, 2: select/index width; 2**SEL_W >= CH required
- DWELL, 4: cycles spent on each channel in scan mode (>=1)

Ports:
- clk  in  1  single clock; all state changes on rising edge
- rst  in  1  reset, asynchronous and active-high
- d_in  in  CH*WIDTH  channel i at bits [i*WIDTH +: WIDTH]
- sel  in  SEL_W  manual channel select
- mode  in  1  0 = manual, 1 = scan
- en_mask  in  CH  channel enable, bit i enables channel i
- m_out  out  WIDTH  registered selected data
- ch_out  out  SEL_W  registered index of the channel shown on m_out
- m_valid  out  1  m_out holds data from an enabled, existing channel
- wrap  out  1  one-cycle pulse at the last dwell cycle of a scan round

## Operation
- Internal state: st in {MANUAL, SCAN}, pointer ptr (SEL_W bits), dwell counter cnt (0..DWELL-1).
- Reset (async, any time, mid-scan included): st=MANUAL, ptr=0, cnt=0. Outputs m_out=0, ch_out=0, m_valid=0, wrap=0.
- MANUAL, each edge:
  - ch_out<=sel.
  - If sel<CH and en_mask[sel]=1: m_out<=d_in[sel] and m_valid<=1. Otherwise m_out<=0 and m_valid<=0.
  - wrap<=0.
- MANUAL to SCAN: on the first edge sampling mode=1, the outputs still follow the MANUAL rule. On the same edge, st<=SCAN, ptr<=lowest enabled channel (0 if en_mask=0), and cnt<=0.
- SCAN, each edge, with p = the current ptr:
  - ch_out<=p.
  - If en_mask[p]=1: m_out<=d_in[p] (live data, re-sampled every cycle) and m_valid<=1. Otherwise m_out<=0 and m_valid<=0.
  - Advance condition: en_mask nonzero AND (cnt=DWELL-1 OR en_mask[p]=0).
    - On advance: ptr<=next enabled channel searching circularly from p+1; cnt<=0; wrap<=(next<=p).
    - Otherwise: cnt<=cnt+1 if en_mask[p]=1; wrap<=0.
  - en_mask=0: ptr and cnt hold, wrap=0, m_valid=0.
  - Single enabled channel: next=p, so ptr stays and wrap pulses every DWELL cycles.
  - Mask change mid-dwell that disables p: one invalid output cycle, then an immediate advance. Enabling a new channel takes effect on the next circular search.
- SCAN to MANUAL: on the first edge sampling mode=0, the outputs follow the MANUAL rule and st<=MANUAL. ptr and cnt hold their values but are unused; they are re-seeded on the next entry to SCAN.
- Channel indices >= CH are never produced by the scanner.

## Timing
- Latency 1 cycle: inputs sampled at edge k appear on outputs after edge k.
- Scan start: the first scanned output is visible after the 2nd edge at which mode=1.
- Each enabled channel appears on ch_out for exactly DWELL consecutive cycles, provided the mask is stable.
- wrap is coincident with the final dwell cycle of the highest enabled channel of the round. It is never high in MANUAL or while en_mask=0.
- There is no combinational input-to-output path.

## Test plan
Common setup for all scenarios: CH=4, WIDTH=8, DWELL=2, d_in channels 0..3 = 0x11, 0x22, 0x33, 0x44.

- Manual sweep: mode=0, en_mask=1111, sel=0,1,2,3 on successive cycles -> m_out=11,22,33,44 one cycle later, m_valid=1, ch_out=sel, wrap=0.
- Manual masked: en_mask=1011, sel=2 -> m_out=00, m_valid=0, ch_out=2. Then sel=3 -> m_out=44, m_valid=1.
- Full scan: mode=1, en_mask=1111 -> ch_out=0,0,1,1,2,2,3,3,0,0 and m_out following the channel data. wrap=1 only on the second cycle at ch 3.
- Skip/single: en_mask=1010 -> ch_out=1,1,3,3,1,1 with wrap on the second 3. en_mask=0100 -> ch_out=2 constantly, wrap high every 2nd cycle.
- Mask change mid-dwell: scanning at ch 1 cycle 1, clear en_mask[1] -> one cycle with ch_out=1 and m_valid=0, then ch_out=2,2. en_mask=0 -> m_valid=0, wrap=0, ptr frozen.
- Reset mid-scan: assert rst between edges -> all outputs 0 immediately (async), st=MANUAL. After release with mode=1, scan restarts at the lowest enabled channel after 2 edges.
